// File: rtl/pc_redirect_ctrl.sv
// Purpose: arbitrates MEM/EX/ID next-PC redirects by pipeline age and drives pc select, target and flushes.
// Latency: zero-cycle combinational pass-through when fetch is ready; otherwise held and re-presented registered.
// Backpressure: while if_ready is low the winner is latched; only strictly older requests may replace it.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_req,
  input  logic [1:0]  mem_kind,
  input  logic [31:0] mem_epc,
  input  logic [31:0] mem_pc,
  input  logic        ex_req,
  input  logic        ex_is_jr,
  input  logic [31:0] ex_target,
  input  logic        id_req,
  input  logic [31:0] id_target,
  input  logic        if_ready,
  output logic [2:0]  pc_sel,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        busy
);

  localparam logic [2:0] SEL_PC4     = 3'b000;
  localparam logic [2:0] SEL_JUMP    = 3'b001;
  localparam logic [2:0] SEL_EPC     = 3'b010;
  localparam logic [2:0] SEL_EXC     = 3'b011;
  localparam logic [2:0] SEL_BRANCH  = 3'b100;
  localparam logic [2:0] SEL_JR      = 3'b101;
  localparam logic [2:0] SEL_REFETCH = 3'b110;
  localparam logic [2:0] SEL_RESET   = 3'b111;

  // Age rank: higher value means older stage (MEM=3, EX=2, ID=1, none=0).
  localparam logic [1:0] RANK_NONE = 2'd0;
  localparam logic [1:0] RANK_ID   = 2'd1;
  localparam logic [1:0] RANK_EX   = 2'd2;
  localparam logic [1:0] RANK_MEM  = 2'd3;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;

  logic        winVld;
  logic [1:0]  winRank;
  logic [2:0]  winSel;
  logic [31:0] winPc;

  logic [2:0]  pendSel;
  logic [31:0] pendPc;
  logic [1:0]  pendRank;

  logic        overwrite;
  logic        loadPend;

  // Pick the oldest valid request and resolve its select code and target.
  always_comb begin
    winVld  = 1'b0;
    winRank = RANK_NONE;
    winSel  = SEL_PC4;
    winPc   = 32'h0;
    if (mem_req && (mem_kind != 2'b00)) begin
      winVld  = 1'b1;
      winRank = RANK_MEM;
      case (mem_kind)
        2'b01: begin
          winSel = SEL_EPC;
          winPc  = mem_epc;
        end
        2'b10: begin
          winSel = SEL_EXC;
          winPc  = EXC_VECTOR;
        end
        default: begin
          winSel = SEL_REFETCH;
          winPc  = mem_pc;
        end
      endcase
    end else if (ex_req) begin
      winVld  = 1'b1;
      winRank = RANK_EX;
      winSel  = ex_is_jr ? SEL_JR : SEL_BRANCH;
      winPc   = ex_target;
    end else if (id_req) begin
      winVld  = 1'b1;
      winRank = RANK_ID;
      winSel  = SEL_JUMP;
      winPc   = id_target;
    end
  end

  // Recover the age rank of the held redirect from its select code.
  always_comb begin
    case (pendSel)
      SEL_EPC, SEL_EXC, SEL_REFETCH: pendRank = RANK_MEM;
      SEL_BRANCH, SEL_JR:            pendRank = RANK_EX;
      SEL_JUMP:                      pendRank = RANK_ID;
      default:                       pendRank = RANK_NONE;
    endcase
  end

  // Only a strictly older request may displace a held one; younger ones die with its flush.
  assign overwrite = (state == PEND) && winVld && (winRank > pendRank);
  assign loadPend  = ((state == IDLE) && winVld && !if_ready) || overwrite;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= BOOT;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      BOOT:    if (if_ready) stateNext = IDLE;
      IDLE:    if (winVld && !if_ready) stateNext = PEND;
      PEND:    if (if_ready) stateNext = IDLE;
      default: stateNext = BOOT;
    endcase
  end

  // Held redirect: loaded on first stall or on an older overwrite, cleared once delivered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pendSel <= SEL_PC4;
      pendPc  <= 32'h0;
    end else if (stateNext != PEND) begin
      pendSel <= SEL_PC4;
      pendPc  <= 32'h0;
    end else if (loadPend) begin
      pendSel <= winSel;
      pendPc  <= winPc;
    end
  end

  // Output decode; flushes fire only in the cycle a request is accepted.
  always_comb begin
    pc_sel         = SEL_PC4;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    busy           = 1'b0;
    if (resetn) begin
      case (state)
        BOOT: begin
          pc_sel         = SEL_RESET;
          redirect_valid = 1'b1;
          redirect_pc    = RESET_PC;
        end
        IDLE: begin
          if (winVld) begin
            pc_sel         = winSel;
            redirect_valid = 1'b1;
            redirect_pc    = winPc;
            flush_if       = 1'b1;
            flush_id       = (winRank >= RANK_EX);
            flush_ex       = (winRank == RANK_MEM);
            busy           = !if_ready;
          end
        end
        PEND: begin
          redirect_valid = 1'b1;
          busy           = 1'b1;
          if (overwrite) begin
            pc_sel      = winSel;
            redirect_pc = winPc;
            flush_if    = 1'b1;
            flush_id    = (winRank >= RANK_EX);
            flush_ex    = (winRank == RANK_MEM);
          end else begin
            pc_sel      = pendSel;
            redirect_pc = pendPc;
          end
        end
        default: begin
          pc_sel = SEL_PC4;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Purpose: randomized and directed check of pc_redirect_ctrl against a behavioural redirect model.
// Latency: inputs driven on the falling edge, outputs compared 1ns later, model advanced on the rising edge.
// Backpressure: if_ready is randomized so held, overwritten and dropped redirects all occur.
module tb_pc_redirect_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_req;
  logic [1:0]  mem_kind;
  logic [31:0] mem_epc;
  logic [31:0] mem_pc;
  logic        ex_req;
  logic        ex_is_jr;
  logic [31:0] ex_target;
  logic        id_req;
  logic [31:0] id_target;
  logic        if_ready;
  logic [2:0]  pc_sel;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic        flush_ex;
  logic        busy;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: "a boot redirect is owed" plus an optional held redirect.
  bit          mBootOwed;
  bit          mHeld;
  logic [2:0]  mHeldSel;
  logic [31:0] mHeldPc;
  bit          nBootOwed;
  bit          nHeld;
  logic [2:0]  nHeldSel;
  logic [31:0] nHeldPc;

  logic [2:0]  eSel;
  logic        eVld;
  logic [31:0] ePc;
  logic        eFi, eFd, eFe, eBusy;

  pc_redirect_ctrl dut (
    .clk(clk), .resetn(resetn),
    .mem_req(mem_req), .mem_kind(mem_kind), .mem_epc(mem_epc), .mem_pc(mem_pc),
    .ex_req(ex_req), .ex_is_jr(ex_is_jr), .ex_target(ex_target),
    .id_req(id_req), .id_target(id_target), .if_ready(if_ready),
    .pc_sel(pc_sel), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Age of a redirect given its select code: exceptions/ERET/refetch oldest, then branches, then jumps.
  function automatic int ageOf(input logic [2:0] sel);
    if (sel == 3'd2 || sel == 3'd3 || sel == 3'd6) return 3;
    if (sel == 3'd4 || sel == 3'd5) return 2;
    if (sel == 3'd1) return 1;
    return 0;
  endfunction

  // Compute expected outputs for the current inputs and the model's state after the next edge.
  task automatic modelEval();
    int          wAge;
    logic [2:0]  wSel;
    logic [31:0] wPc;
    bit          take;
    wAge = 0; wSel = 3'd0; wPc = 32'h0;
    if (mem_req && mem_kind == 2'd1)      begin wAge = 3; wSel = 3'd2; wPc = mem_epc; end
    else if (mem_req && mem_kind == 2'd2) begin wAge = 3; wSel = 3'd3; wPc = EXC_PC; end
    else if (mem_req && mem_kind == 2'd3) begin wAge = 3; wSel = 3'd6; wPc = mem_pc; end
    else if (ex_req)  begin wAge = 2; wSel = ex_is_jr ? 3'd5 : 3'd4; wPc = ex_target; end
    else if (id_req)  begin wAge = 1; wSel = 3'd1; wPc = id_target; end

    {eSel, eVld, ePc, eFi, eFd, eFe, eBusy} = '0;
    nBootOwed = mBootOwed; nHeld = mHeld; nHeldSel = mHeldSel; nHeldPc = mHeldPc;
    take = 1'b0;

    if (!resetn) begin
      nBootOwed = 1'b1; nHeld = 1'b0;
    end else if (mBootOwed) begin
      eSel = 3'd7; eVld = 1'b1; ePc = RST_PC;
      if (if_ready) nBootOwed = 1'b0;
    end else if (mHeld) begin
      take = (wAge > ageOf(mHeldSel));
      eVld = 1'b1; eBusy = 1'b1;
      eSel = take ? wSel : mHeldSel;
      ePc  = take ? wPc  : mHeldPc;
      if (take) begin nHeldSel = wSel; nHeldPc = wPc; end
      if (if_ready) nHeld = 1'b0;
    end else if (wAge > 0) begin
      take = 1'b1;
      eVld = 1'b1; eSel = wSel; ePc = wPc; eBusy = !if_ready;
      if (!if_ready) begin nHeld = 1'b1; nHeldSel = wSel; nHeldPc = wPc; end
    end
    if (take) begin
      eFi = 1'b1;
      eFd = (wAge >= 2);
      eFe = (wAge == 3);
    end
  endtask

  task automatic startCycle();
    @(negedge clk);
    mem_req = 0; mem_kind = 0; mem_epc = 0; mem_pc = 0;
    ex_req = 0; ex_is_jr = 0; ex_target = 0;
    id_req = 0; id_target = 0; if_ready = 1;
  endtask

  task automatic checkCycle();
    #1;
    modelEval();
    checkVal("pc_sel", 32'(pc_sel), 32'(eSel));
    checkVal("redirect_valid", 32'(redirect_valid), 32'(eVld));
    checkVal("redirect_pc", redirect_pc, ePc);
    checkVal("flush_if", 32'(flush_if), 32'(eFi));
    checkVal("flush_id", 32'(flush_id), 32'(eFd));
    checkVal("flush_ex", 32'(flush_ex), 32'(eFe));
    checkVal("busy", 32'(busy), 32'(eBusy));
  endtask

  task automatic endCycle();
    @(posedge clk);
    mBootOwed = nBootOwed; mHeld = nHeld; mHeldSel = nHeldSel; mHeldPc = nHeldPc;
  endtask

  initial begin
    resetn = 0;
    mBootOwed = 1; mHeld = 0; mHeldSel = 0; mHeldPc = 0;

    // Held in reset: everything quiet.
    startCycle(); checkCycle(); endCycle();

    // Release: one cycle of reset vector, then idle PC+4.
    startCycle(); resetn = 1; checkCycle();
    checkVal("boot_sel", 32'(pc_sel), 32'd7);
    checkVal("boot_pc", redirect_pc, RST_PC);
    endCycle();
    startCycle(); checkCycle();
    checkVal("idle_sel", 32'(pc_sel), 32'd0);
    checkVal("idle_vld", 32'(redirect_valid), 32'd0);
    endCycle();

    // EX JR pass-through.
    startCycle(); ex_req = 1; ex_is_jr = 1; ex_target = 32'h8000_1000; checkCycle();
    checkVal("jr_sel", 32'(pc_sel), 32'd5);
    checkVal("jr_pc", redirect_pc, 32'h8000_1000);
    checkVal("jr_flush", 32'({flush_if, flush_id, flush_ex}), 32'b110);
    endCycle();

    // All three stages at once: exception wins.
    startCycle(); id_req = 1; id_target = 32'h8000_0040; ex_req = 1; ex_target = 32'h8000_2000;
    mem_req = 1; mem_kind = 2'b10; checkCycle();
    checkVal("exc_sel", 32'(pc_sel), 32'd3);
    checkVal("exc_pc", redirect_pc, EXC_PC);
    checkVal("exc_flush", 32'({flush_if, flush_id, flush_ex}), 32'b111);
    endCycle();

    // ID jump held for three stalled cycles.
    for (int i = 0; i < 3; i++) begin
      startCycle(); id_req = 1; id_target = 32'h8000_0040; if_ready = 0; checkCycle();
      checkVal("hold_sel", 32'(pc_sel), 32'd1);
      checkVal("hold_busy", 32'(busy), 32'd1);
      checkVal("hold_fi", 32'(flush_if), (i == 0) ? 32'd1 : 32'd0);
      endCycle();
    end
    startCycle(); checkCycle();
    checkVal("deliver_pc", redirect_pc, 32'h8000_0040);
    endCycle();
    startCycle(); checkCycle();
    checkVal("after_busy", 32'(busy), 32'd0);
    endCycle();

    // Held ID jump overwritten by ERET; later EX request dropped.
    startCycle(); id_req = 1; id_target = 32'h8000_0080; if_ready = 0; checkCycle(); endCycle();
    startCycle(); mem_req = 1; mem_kind = 2'b01; mem_epc = 32'h8000_0200; if_ready = 0; checkCycle();
    checkVal("eret_sel", 32'(pc_sel), 32'd2);
    checkVal("eret_pc", redirect_pc, 32'h8000_0200);
    checkVal("eret_flush", 32'({flush_if, flush_id, flush_ex}), 32'b111);
    endCycle();
    startCycle(); ex_req = 1; ex_target = 32'h8000_3000; if_ready = 0; checkCycle();
    checkVal("drop_sel", 32'(pc_sel), 32'd2);
    checkVal("drop_flush", 32'({flush_if, flush_id, flush_ex}), 32'b000);
    endCycle();
    startCycle(); checkCycle();
    checkVal("eret_deliver", redirect_pc, 32'h8000_0200);
    endCycle();

    // Reset while holding a redirect.
    startCycle(); id_req = 1; id_target = 32'h8000_0500; if_ready = 0; checkCycle(); endCycle();
    startCycle(); resetn = 0; checkCycle();
    checkVal("rst_vld", 32'(redirect_valid), 32'd0);
    endCycle();
    startCycle(); resetn = 1; checkCycle();
    checkVal("reboot_sel", 32'(pc_sel), 32'd7);
    endCycle();
    startCycle(); checkCycle();
    checkVal("no_stale", 32'(redirect_valid), 32'd0);
    endCycle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      startCycle();
      resetn    = ($urandom_range(0, 299) != 0);
      mem_req   = ($urandom_range(0, 99) < 20);
      mem_kind  = 2'($urandom_range(0, 3));
      mem_epc   = $urandom;
      mem_pc    = $urandom;
      ex_req    = ($urandom_range(0, 99) < 30);
      ex_is_jr  = 1'($urandom_range(0, 1));
      ex_target = $urandom;
      id_req    = ($urandom_range(0, 99) < 35);
      id_target = $urandom;
      if_ready  = ($urandom_range(0, 99) < 55);
      checkCycle();
      endCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
